// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory operand port between the UART loader (0) and the CPU core (1),
// sequencing one IDLE -> ACCESS -> DONE access per grant.
module mem_port_arbiter #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_write,
    output logic                  mem_drive,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    last_grant_reg, last_grant_next;
    logic                    id_reg, id_next;
    logic                    mem_write_reg, mem_write_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
    logic [WORD_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [WORD_WIDTH-1:0]   rdata_reg, rdata_next;

    logic                    eff_req0;
    logic                    eff_req1;
    logic                    winner;

    assign eff_req0 = req0;
    assign eff_req1 = req1 & ~prog_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            id_reg         <= id_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            rdata_reg      <= rdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        id_next         = id_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        rdata_next      = rdata_reg;
        winner          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (eff_req0 | eff_req1) begin
                    // On contention the requester that did not win last time gets the port.
                    winner          = (eff_req0 & eff_req1) ? ~last_grant_reg : eff_req1;
                    id_next         = winner;
                    last_grant_next = winner;
                    mem_write_next  = winner ? we1 : we0;
                    mem_addr_next   = winner ? addr1 : addr0;
                    mem_wdata_next  = winner ? wdata1 : wdata0;
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                if (!mem_write_reg) begin
                    rdata_next = mem_rdata;
                end
                mem_write_next = 1'b0;
                state_next     = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next     = IDLE;
                mem_write_next = 1'b0;
            end
        endcase
    end

    // Acks are decoded from state so a reset edge removes them together with the FSM.
    assign ack0      = (state_reg == DONE) && (id_reg == 1'b0);
    assign ack1      = (state_reg == DONE) && (id_reg == 1'b1);
    assign busy      = (state_reg == ACCESS) || (state_reg == DONE);
    assign rdata     = rdata_reg;
    assign mem_write = mem_write_reg;
    assign mem_drive = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus hand-written
// arbitration, prog_mode, reset-during-access and address-change sequences.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic       prog_mode;
    logic       req0, req1;
    logic       we0, we1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata;
    logic       busy;
    logic       mem_write;
    logic       mem_drive;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic       mem_init;
    logic [7:0] mem [0:7];

    int checks;
    int errors;

    mem_port_arbiter #(
        .WORD_WIDTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_mode (prog_mode),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .mem_write (mem_write),
        .mem_drive (mem_drive),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behaves like the real array: write at the edge, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'(8'h10 + i);
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic       pm;
        logic       req0;
        logic       we0;
        logic [2:0] addr0;
        logic [7:0] wdata0;
        logic       req1;
        logic       we1;
        logic [2:0] addr1;
        logic [7:0] wdata1;
        logic       exp_ack0;
        logic       exp_ack1;
        logic       exp_write;
        logic [2:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        prog_mode = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'b0;  we1 = 1'b0;
        addr0 = 3'd0; addr1 = 3'd0;
        wdata0 = 8'h00; wdata1 = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called one time unit after a rising edge with the DUT in IDLE.
    task automatic run_vec(input string name, input vec_t v);
        prog_mode = v.pm;
        req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
        req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1;
        @(negedge clk);
        check({name, " idle busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, " access busy"}, 32'(busy), 32'd1);
        check({name, " access mem_write"}, 32'(mem_write), 32'(v.exp_write));
        check({name, " access mem_drive"}, 32'(mem_drive), 32'(v.exp_write));
        check({name, " access mem_addr"}, 32'(mem_addr), 32'(v.exp_addr));
        if (v.exp_write) check({name, " access mem_wdata"}, 32'(mem_wdata), 32'(v.exp_wdata));
        check({name, " access acks"}, 32'({ack0, ack1}), 32'd0);
        @(negedge clk);
        check({name, " done ack0"}, 32'(ack0), 32'(v.exp_ack0));
        check({name, " done ack1"}, 32'(ack1), 32'(v.exp_ack1));
        check({name, " done rdata"}, 32'(rdata), 32'(v.exp_rdata));
        check({name, " done mem_write"}, 32'(mem_write), 32'd0);
        $display("%s: ack0=%0b ack1=%0b rdata=%02h", name, ack0, ack1, rdata);
        @(posedge clk);
        #1 clear_inputs();
    endtask

    initial begin
        int         ack_count;
        int         both_count;
        int         drive_bad;
        logic [3:0] order;
        logic       ack1_seen;
        logic       busy_seen;

        checks = 0;
        errors = 0;
        mem_init = 1'b1;
        rst = 1'b1;
        clear_inputs();

        //            pm  r0   we0  a0    wd0    r1   we1  a1    wd1    ak0  ak1  wr   eaddr ewdata erdata
        vecs[0] = '{1'b0,1'b1,1'b1,3'd3,8'hA5, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,1'b1,3'd3,8'hA5,8'h00};
        vecs[1] = '{1'b0,1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,3'd3,8'h00, 1'b0,1'b1,1'b0,3'd3,8'h00,8'hA5};
        vecs[2] = '{1'b0,1'b1,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,1'b0,3'd0,8'h00,8'h10};
        vecs[3] = '{1'b0,1'b0,1'b0,3'd0,8'h00, 1'b1,1'b1,3'd7,8'h5A, 1'b0,1'b1,1'b1,3'd7,8'h5A,8'h10};
        vecs[4] = '{1'b0,1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,3'd7,8'h00, 1'b0,1'b1,1'b0,3'd7,8'h00,8'h5A};
        vecs[5] = '{1'b0,1'b1,1'b0,3'd4,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,1'b0,3'd4,8'h00,8'h14};
        vecs[6] = '{1'b1,1'b1,1'b1,3'd6,8'h66, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,1'b1,3'd6,8'h66,8'h14};

        @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("reset acks", 32'({ack0, ack1}), 32'd0);
        check("reset rdata", 32'(rdata), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset mem_write/drive", 32'({mem_write, mem_drive}), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // prog_mode masks a held core request, loader still served, core granted once unmasked.
        prog_mode = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3;
        ack1_seen = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ack1_seen |= ack1;
            busy_seen |= busy;
        end
        check("masked ack1", 32'(ack1_seen), 32'd0);
        check("masked busy", 32'(busy_seen), 32'd0);
        @(posedge clk);
        #1 req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wdata0 = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        check("pm loader mem_write", 32'(mem_write), 32'd1);
        check("pm loader mem_addr", 32'(mem_addr), 32'd5);
        @(negedge clk);
        check("pm loader acks", 32'({ack0, ack1}), 32'b10);
        $display("pm loader: ack0=%0b ack1=%0b", ack0, ack1);
        @(posedge clk);
        #1 req0 = 1'b0; prog_mode = 1'b0;
        @(negedge clk);
        check("unmask idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("unmask access addr", 32'(mem_addr), 32'd3);
        check("unmask access write", 32'(mem_write), 32'd0);
        @(negedge clk);
        check("unmask acks", 32'({ack0, ack1}), 32'b01);
        check("unmask rdata", 32'(rdata), 32'hA5);
        $display("unmask core: ack1=%0b rdata=%02h", ack1, rdata);
        @(posedge clk);
        #1 clear_inputs();

        // Both requesters held from reset: alternating grants starting with the loader.
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; wdata0 = 8'hAB;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 8'h22;
        ack_count = 0;
        both_count = 0;
        drive_bad = 0;
        order = 4'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_drive !== mem_write) drive_bad++;
            if (ack0 && ack1) both_count++;
            if (ack0 || ack1) begin
                ack_count++;
                order = {order[2:0], ack1};
                $display("contention grant %0d: ack0=%0b ack1=%0b", ack_count, ack0, ack1);
            end
        end
        @(posedge clk);
        #1 clear_inputs();
        check("contention ack count", 32'(ack_count), 32'd4);
        check("contention both acks", 32'(both_count), 32'd0);
        check("contention order", 32'(order), 32'b0101);
        check("contention drive==write", 32'(drive_bad), 32'd0);

        // Reset during the ACCESS cycle of a core write: no ack, write still lands.
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        check("rst-mid access mem_write", 32'(mem_write), 32'd1);
        check("rst-mid access mem_addr", 32'(mem_addr), 32'd2);
        rst = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        check("rst-mid acks", 32'({ack0, ack1}), 32'd0);
        check("rst-mid busy", 32'(busy), 32'd0);
        check("rst-mid mem outputs", 32'({mem_write, mem_drive, mem_addr, mem_wdata}), 32'd0);
        check("rst-mid rdata", 32'(rdata), 32'd0);
        $display("reset mid-access: busy=%0b ack1=%0b", busy, ack1);
        @(posedge clk);
        #1 rst = 1'b0;
        run_vec("readback after rst",
                '{1'b0,1'b1,1'b0,3'd2,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,1'b0,3'd2,8'h00,8'h3C});

        // Core read of addr 1 whose address input moves during ACCESS.
        req1 = 1'b1; we1 = 1'b0; addr1 = 3'd1;
        @(negedge clk);
        @(negedge clk);
        check("addr change access mem_addr", 32'(mem_addr), 32'd1);
        addr1 = 3'd6;
        @(negedge clk);
        check("addr change acks", 32'({ack0, ack1}), 32'b01);
        check("addr change rdata", 32'(rdata), 32'hAB);
        $display("addr change read: ack1=%0b rdata=%02h", ack1, rdata);
        @(posedge clk);
        #1 clear_inputs();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
